// File: rtl/sram_controller_pkg.sv
// Shared types and widths for the 32-bit-to-16-bit SRAM controller.
// Holds the FSM state encoding and the latched request payload.
package sram_controller_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WORD_W      = SRAM_ADDR_W - 1;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_e;

  // Request captured on IDLE -> LOW and held for the whole access
  typedef struct packed {
    logic              is_wr;
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: request, data and the ready/freeze line.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline access into two 16-bit SRAM phases plus idle padding;
// ready stays low while an access is in flight so the pipeline freezes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned       WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  req_t                    req_q, req_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic                    we_n_q, we_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    dq_oe_q, dq_oe_d;
  logic [SRAM_DATA_W-1:0]  dq_out_q, dq_out_d;

  logic                    req_c;
  logic                    phase_c;
  logic [WORD_W-1:0]       word_c;
  logic                    unused_addr_c;

  assign req_c  = bus.rd_en | bus.wr_en;
  // Only bits [18:2] of (address - BASE_ADDR) matter; the byte offset is dropped
  assign word_c = WORD_W'(bus.address[18:2] - BASE_ADDR[18:2]);
  assign unused_addr_c = ^{bus.address[ADDR_W-1:19], bus.address[1:0]};

  // State, request latch and read-data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          state_d     = LOW;
          req_d.is_wr = bus.wr_en;
          req_d.word  = word_c;
          req_d.wdata = bus.write_data;
        end
      end
      LOW: begin
        state_d = HIGH;
        if (!req_q.is_wr) rdata_d[SRAM_DATA_W-1:0] = SRAM_DQ;
      end
      HIGH: begin
        state_d = WAIT;
        cnt_d   = '0;
        if (!req_q.is_wr) rdata_d[DATA_W-1:SRAM_DATA_W] = SRAM_DQ;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so they line up with LOW/HIGH
  always_comb begin
    phase_c     = (state_d == LOW) || (state_d == HIGH);
    sram_addr_d = {req_d.word, state_d == HIGH};
    we_n_d      = !(phase_c && req_d.is_wr);
    oe_n_d      = !(phase_c && !req_d.is_wr);
    dq_oe_d     = phase_c && req_d.is_wr;
    dq_out_d    = (state_d == HIGH) ? req_d.wdata[DATA_W-1:SRAM_DATA_W]
                                    : req_d.wdata[SRAM_DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  // ready doubles as the active-low freeze for every pipeline stage
  always_comb begin
    bus.ready = ((state_q == IDLE) && !req_c) || (state_q == DONE);
  end

  assign bus.read_data = rdata_q;
  assign SRAM_ADDR     = sram_addr_q;
  assign SRAM_WE_N     = we_n_q;
  assign SRAM_OE_N     = oe_n_q;
  assign SRAM_CE_N     = 1'b0;
  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign SRAM_DQ       = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: table of accesses plus reset and hold sequences,
// against a behavioural 256K x 16 SRAM.
module sram_model
  import sram_controller_pkg::*;
(
  input  logic                   clk,
  inout  wire  [SRAM_DATA_W-1:0] dq,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic                   we_n,
  input  logic                   oe_n,
  input  logic                   ce_n,
  input  logic                   ub_n,
  input  logic                   lb_n
);
  logic [SRAM_DATA_W-1:0] mem [0:(1<<SRAM_ADDR_W)-1];

  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[addr][7:0]  <= dq[7:0];
      if (!ub_n) mem[addr][15:8] <= dq[15:8];
    end
  end
endmodule

module tb_sram_controller;
  import sram_controller_pkg::*;

  typedef struct {
    int          sel;
    logic        wr;
    logic        rd;
    logic        mangle;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [17:0] exp_a;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    int          exp_low;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_controller_if bus0();
  sram_controller_if bus1();

  wire  [15:0] dq0, dq1;
  logic [17:0] a0, a1;
  logic we0, oe0, ce0, ub0, lb0;
  logic we1, oe1, ce1, ub1, lb1;
  wire  dq0_z = (dq0 === 16'hzzzz);
  wire  dq1_z = (dq1 === 16'hzzzz);

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .SRAM_DQ(dq0), .SRAM_ADDR(a0),
    .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );
  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .SRAM_DQ(dq1), .SRAM_ADDR(a1),
    .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );
  sram_model u_sram0 (.clk(clk), .dq(dq0), .addr(a0), .we_n(we0), .oe_n(oe0),
                      .ce_n(ce0), .ub_n(ub0), .lb_n(lb0));
  sram_model u_sram1 (.clk(clk), .dq(dq1), .addr(a1), .we_n(we1), .oe_n(oe1),
                      .ce_n(ce1), .ub_n(ub1), .lb_n(lb1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus0.wr_en = wr; bus0.rd_en = rd; bus0.address = addr; bus0.write_data = data;
    end else begin
      bus1.wr_en = wr; bus1.rd_en = rd; bus1.address = addr; bus1.write_data = data;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.ready : bus1.ready;
  endfunction
  function automatic logic get_we(input int sel);
    return (sel == 0) ? we0 : we1;
  endfunction
  function automatic logic get_oe(input int sel);
    return (sel == 0) ? oe0 : oe1;
  endfunction
  function automatic logic get_z(input int sel);
    return (sel == 0) ? dq0_z : dq1_z;
  endfunction
  function automatic logic [15:0] get_dq(input int sel);
    return (sel == 0) ? dq0 : dq1;
  endfunction
  function automatic logic [17:0] get_addr(input int sel);
    return (sel == 0) ? a0 : a1;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.read_data : bus1.read_data;
  endfunction
  function automatic logic [15:0] mem_word(input int sel, input logic [17:0] idx);
    return (sel == 0) ? u_sram0.mem[idx] : u_sram1.mem[idx];
  endfunction

  // Runs one access from IDLE to DONE, recording what the SRAM pins did each cycle
  task automatic apply_vec(input string tag, input vec_t v);
    int          lowc;
    logic [31:0] rd_done;
    logic [17:0] a_lo, a_hi;
    logic [15:0] dq_lo, dq_hi;
    logic        we_seen, oe_seen, z_bad;
    lowc = 0; rd_done = '0; a_lo = '0; a_hi = '0; dq_lo = '0; dq_hi = '0;
    we_seen = 1'b0; oe_seen = 1'b0; z_bad = 1'b0;
    @(negedge clk);
    set_req(v.sel, v.wr, v.rd, v.addr, v.wdata);
    #1;
    while (!get_ready(v.sel) && lowc < 40) begin
      if (lowc != 1 && lowc != 2 && !get_z(v.sel)) z_bad = 1'b1;
      if (!get_we(v.sel)) we_seen = 1'b1;
      if (!get_oe(v.sel)) oe_seen = 1'b1;
      if (lowc == 1) begin
        a_lo  = get_addr(v.sel);
        dq_lo = get_dq(v.sel);
        if (v.mangle) set_req(v.sel, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
      end
      if (lowc == 2) begin
        a_hi  = get_addr(v.sel);
        dq_hi = get_dq(v.sel);
      end
      lowc++;
      @(negedge clk);
      #1;
    end
    if (!get_z(v.sel)) z_bad = 1'b1;
    rd_done = get_rdata(v.sel);
    set_req(v.sel, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, " ready-low cycles"}, 32'(lowc), 32'(v.exp_low));
    chk({tag, " addr LOW"}, 32'(a_lo), 32'(v.exp_a));
    chk({tag, " addr HIGH"}, 32'(a_hi), 32'(v.exp_a | 18'd1));
    chk({tag, " dq LOW"}, 32'(dq_lo), 32'(v.exp_lo));
    chk({tag, " dq HIGH"}, 32'(dq_hi), 32'(v.exp_hi));
    chk({tag, " read_data in DONE"}, rd_done, v.exp_rd);
    chk({tag, " dq released outside phases"}, 32'(z_bad), 32'd0);
    if (v.wr) begin
      chk({tag, " oe during write"}, 32'(oe_seen), 32'd0);
      chk({tag, " sram lo word"}, 32'(mem_word(v.sel, v.exp_a)), 32'(v.exp_lo));
      chk({tag, " sram hi word"}, 32'(mem_word(v.sel, v.exp_a | 18'd1)), 32'(v.exp_hi));
    end else begin
      chk({tag, " we during read"}, 32'(we_seen), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [12];
    vec_t        rv;
    int          cyc;
    logic        resumed;
    logic [15:0] lo4, hi5;

    // sel wr rd mangle addr wdata exp_rd exp_a exp_lo exp_hi exp_low
    tbl[0]  = '{0, 1'b1, 1'b0, 1'b0, 32'd1024,       32'hDEADBEEF, 32'h00000000, 18'h00000, 16'hBEEF, 16'hDEAD, 6};
    tbl[1]  = '{0, 1'b0, 1'b1, 1'b0, 32'd1024,       32'h00000000, 32'hDEADBEEF, 18'h00000, 16'hBEEF, 16'hDEAD, 6};
    tbl[2]  = '{0, 1'b1, 1'b0, 1'b0, 32'd1028,       32'h12345678, 32'hDEADBEEF, 18'h00002, 16'h5678, 16'h1234, 6};
    tbl[3]  = '{0, 1'b0, 1'b1, 1'b0, 32'd1031,       32'hFFFF0000, 32'h12345678, 18'h00002, 16'h5678, 16'h1234, 6};
    tbl[4]  = '{0, 1'b1, 1'b1, 1'b0, 32'd1024,       32'hA5A5A5A5, 32'h12345678, 18'h00000, 16'hA5A5, 16'hA5A5, 6};
    tbl[5]  = '{0, 1'b0, 1'b1, 1'b0, 32'd1024,       32'h00000000, 32'hA5A5A5A5, 18'h00000, 16'hA5A5, 16'hA5A5, 6};
    tbl[6]  = '{0, 1'b1, 1'b0, 1'b0, 32'h000803FC,   32'h0F0FF0F0, 32'hA5A5A5A5, 18'h3FFFE, 16'hF0F0, 16'h0F0F, 6};
    tbl[7]  = '{0, 1'b0, 1'b1, 1'b0, 32'd1020,       32'h00000000, 32'h0F0FF0F0, 18'h3FFFE, 16'hF0F0, 16'h0F0F, 6};
    tbl[8]  = '{0, 1'b1, 1'b0, 1'b1, 32'd1036,       32'h55667788, 32'h0F0FF0F0, 18'h00006, 16'h7788, 16'h5566, 6};
    tbl[9]  = '{0, 1'b0, 1'b1, 1'b0, 32'h80000400,   32'h00000000, 32'hA5A5A5A5, 18'h00000, 16'hA5A5, 16'hA5A5, 6};
    tbl[10] = '{1, 1'b1, 1'b0, 1'b0, 32'd1024,       32'h0BADC0DE, 32'h00000000, 18'h00000, 16'hC0DE, 16'h0BAD, 4};
    tbl[11] = '{1, 1'b0, 1'b1, 1'b0, 32'd1024,       32'h00000000, 32'h0BADC0DE, 18'h00000, 16'hC0DE, 16'h0BAD, 4};

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset ready", 32'(bus0.ready), 32'd1);
    chk("reset we_n", 32'(we0), 32'd1);
    chk("reset oe_n", 32'(oe0), 32'd1);
    chk("reset dq high-z", 32'(dq0_z), 32'd1);
    chk("reset read_data", bus0.read_data, 32'h0);
    chk("tied ce/ub/lb", {29'd0, ce0, ub0, lb0}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply_vec($sformatf("v%0d", i), tbl[i]);
    end

    // Request held through DONE must not restart straight away
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'd1040, 32'h01020304);
    cyc = 0;
    #1;
    while (!bus0.ready && cyc < 40) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("hold ready-low cycles", 32'(cyc), 32'd6);
    chk("hold DONE ready", 32'(bus0.ready), 32'd1);
    @(negedge clk);
    #1;
    chk("hold IDLE ready with request", 32'(bus0.ready), 32'd0);
    chk("hold no restart we_n", 32'(we0), 32'd1);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("idle ready", 32'(bus0.ready), 32'd1);
    chk("idle strobes", {30'd0, we0, oe0}, 32'd3);

    // Reset during HIGH of a write abandons the access
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    #1;
    chk("mid-write HIGH we_n", 32'(we0), 32'd0);
    chk("mid-write HIGH dq", 32'(dq0), 32'h0000CAFE);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("post-reset ready", 32'(bus0.ready), 32'd1);
    chk("post-reset we_n", 32'(we0), 32'd1);
    chk("post-reset oe_n", 32'(oe0), 32'd1);
    chk("post-reset dq high-z", 32'(dq0_z), 32'd1);
    chk("post-reset read_data", bus0.read_data, 32'h0);
    rst = 1'b0;
    resumed = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (!we0 || !bus0.ready) resumed = 1'b1;
    end
    chk("abandoned access stays idle", 32'(resumed), 32'd0);
    lo4 = u_sram0.mem[4];
    hi5 = u_sram0.mem[5];
    chk("interrupted write low half", 32'(lo4), 32'h0000F00D);
    rv = '{0, 1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, {hi5, lo4}, 18'h00004, lo4, hi5, 6};
    apply_vec("post-reset read", rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: BASE_ADDR, 32'd1024, byte address that maps to SRAM word 0.
REQ-002 Parameter: WAIT_CYCLES, 3, idle cycles inserted after the two halfword phases (range 1..15).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  store request from the MEM stage, held until ready.
REQ-007 rd_en  in  1  load request from the MEM stage, held until ready.
REQ-008 address  in  32  byte address (ALU result).
REQ-009 write_data  in  32  store data (Rm value).
REQ-010 read_data  out  32  registered load data.
REQ-011 ready  out  1  high = pipeline may advance; low = freeze all stages.
REQ-012 SRAM_DQ  inout  16  SRAM data bus.
REQ-013 SRAM_ADDR  out  18  SRAM halfword address.
REQ-014 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.

Function
REQ-015 The FSM states SHALL be IDLE, LOW, HIGH, WAIT and DONE.
REQ-016 IDLE -> LOW when rd_en or wr_en is high; otherwise the FSM stays in IDLE.
REQ-017 LOW -> HIGH and HIGH -> WAIT, unconditionally.
REQ-018 In WAIT, a counter SHALL count from 0. The FSM moves WAIT -> DONE when the count reaches WAIT_CYCLES-1.
REQ-019 DONE -> IDLE, unconditionally.
REQ-020 ready SHALL be 0 in IDLE when a request is present, and 0 in LOW, HIGH and WAIT.
REQ-021 ready SHALL be 1 in IDLE when no request is present, and 1 in DONE.
REQ-022 Each access therefore holds ready low for exactly WAIT_CYCLES+3 cycles.
REQ-023 Address mapping: off = address - BASE_ADDR (mod 2^32); word = off[18:2].
REQ-024 SRAM_ADDR = {word[16:0], 0} in LOW and {word[16:0], 1} in HIGH.
REQ-025 address[1:0] SHALL be ignored.
REQ-026 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be tied to 0.
REQ-027 SRAM_OE_N SHALL be 0 during a read in LOW and HIGH, and 1 otherwise.
REQ-028 SRAM_WE_N SHALL be 0 only during a write in LOW and HIGH.
REQ-029 Write: SRAM_DQ SHALL carry write_data[15:0] in LOW and write_data[31:16] in HIGH, and be high-Z in all other states.
REQ-030 Read: SRAM_DQ SHALL be high-Z throughout.
REQ-031 Read: SRAM_DQ SHALL be sampled into read_data[15:0] at the end of LOW and into read_data[31:16] at the end of HIGH.
REQ-032 read_data SHALL hold its value until the next read; writes SHALL NOT alter it.
REQ-033 rd_en and wr_en both high SHALL be treated as a write.
REQ-034 The request type and address SHALL be latched on the IDLE -> LOW transition; later input changes are ignored until DONE.
REQ-035 A request still asserted in DONE SHALL NOT restart an access; a new access may start only from IDLE on the following cycle.

Reset
REQ-036 rst high at a clock edge SHALL force, including mid-access: state IDLE, WAIT counter 0, read_data 0.
REQ-037 rst high SHALL also force: SRAM_WE_N 1, SRAM_OE_N 1, SRAM_DQ high-Z.
REQ-038 ready after reset SHALL follow REQ-020/REQ-021 from the IDLE state.
REQ-039 An access interrupted by reset SHALL be abandoned and SHALL NOT resume.

Structure
REQ-040 A shared package SHALL hold the state encoding (3 bits), SRAM_ADDR_W = 18 and SRAM_DATA_W = 16.
REQ-041 The RTL SHALL be a single flat module.
REQ-042 The bench SHALL contain one behavioural sub-module, sram_model: 256K x 16 array with combinational read on OE_N low and a write on WE_N low.
REQ-043 sram_controller SHALL connect to the pipeline's MEM stage.
REQ-044 ready, inverted, SHALL be ORed into the global freeze.

Verification
REQ-045 Write 0xDEADBEEF to 1024 -> SRAM[0] = 0xBEEF, SRAM[1] = 0xDEAD; ready low for exactly 6 cycles, then high for 1 cycle.
REQ-046 Read 1024 after REQ-045 -> read_data = 0xDEADBEEF in DONE; SRAM_DQ never driven by the controller.
REQ-047 Write 0x12345678 to 1028, then read 1031 -> SRAM_ADDR 2 then 3; read_data = 0x12345678.
REQ-048 With WAIT_CYCLES = 1: read and write each hold ready low for exactly 4 cycles.
REQ-049 rst asserted during HIGH of a write -> next cycle: IDLE, WE_N = 1, DQ high-Z, read_data = 0; a new read returns the SRAM contents.
REQ-050 rd_en and wr_en both high with address 1024 and data 0xA5A5A5A5 -> write performed, read_data unchanged; idle with no request -> ready = 1 and SRAM controls inactive.
